// File: rtl/gate_activation.sv
// rtl/gate_activation.sv - element-serial sigmoid/tanh activation stage for the LSTM gate vector
//
// Captures a HIDDEN_SZ-element signed Q(QN).(QM) vector on each rising edge of
// dataReady_gate. Each element passes through a shift-only piecewise-linear
// sigmoid, or tanh when enabled, at one element per clock.
// Optional feature macro: GATE_ACT_TANH_EN adds the tanhSel port and the tanh path.
//
// Ports:
//   clock          in   sole clock, rising edge
//   reset          in   synchronous, active-high
//   gateOutput     in   packed input vector, element k at [k*BITWIDTH +: BITWIDTH]
//   dataReady_gate in   level; a rising edge presents a new vector
//   tanhSel        in   (GATE_ACT_TANH_EN only) 1 = tanh, 0 = sigmoid, sampled at capture
//   actOutput      out  packed activated vector, same packing as gateOutput
//   dataReady_act  out  high while actOutput holds a complete result
//   busy           out  high from capture until the last element is written
module gate_activation #(
   parameter  int HIDDEN_SZ      = 32,
   parameter  int QN             = 6,
   parameter  int QM             = 11,
   localparam int BITWIDTH       = QN + QM + 1,
   localparam int LAYER_BITWIDTH = BITWIDTH * HIDDEN_SZ
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [LAYER_BITWIDTH-1:0] gateOutput,
   input  logic                      dataReady_gate,
`ifdef GATE_ACT_TANH_EN
   input  logic                      tanhSel,
`endif
   output logic [LAYER_BITWIDTH-1:0] actOutput,
   output logic                      dataReady_act,
   output logic                      busy
);

   localparam int IDXW = (HIDDEN_SZ > 1) ? $clog2(HIDDEN_SZ) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(HIDDEN_SZ - 1);

   // Fixed-point constants and segment boundaries, all scaled by 2^QM.
   localparam logic [BITWIDTH-1:0] ONE     = BITWIDTH'(1 << QM);        // 1.0
   localparam logic [BITWIDTH-1:0] HALF    = BITWIDTH'(1 << (QM - 1));  // 0.5
   localparam logic [BITWIDTH-1:0] K_0625  = BITWIDTH'(5 << (QM - 3));  // 0.625
   localparam logic [BITWIDTH-1:0] K_08438 = BITWIDTH'(27 << (QM - 5)); // 0.84375
   localparam logic [BITWIDTH-1:0] B_2375  = BITWIDTH'(19 << (QM - 3)); // 2.375
   localparam logic [BITWIDTH-1:0] B_5     = BITWIDTH'(5 << QM);        // 5.0
   localparam logic [BITWIDTH-1:0] MAX_POS = {1'b0, {(BITWIDTH-1){1'b1}}};
   localparam logic [BITWIDTH-1:0] MIN_NEG = {1'b1, {(BITWIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                    state_q;
   logic                      prev_q;
   logic [LAYER_BITWIDTH-1:0] vec_q;
   logic [IDXW-1:0]           idx_q;
   logic                      drain_q;
`ifdef GATE_ACT_TANH_EN
   logic                      tanh_q;
`endif

   // Issue register: element selected from the latched vector (doubled for tanh).
   logic                      iss_vld_q;
   logic [BITWIDTH-1:0]       iss_x_q;
   logic [IDXW-1:0]           iss_idx_q;

   // Stage 1: sign, magnitude and segment.
   logic                      s1_vld_q;
   logic                      s1_neg_q;
   logic [BITWIDTH-1:0]       s1_abs_q;
   logic [1:0]                s1_seg_q;
   logic [IDXW-1:0]           s1_idx_q;

   logic [LAYER_BITWIDTH-1:0] act_q;
   logic                      rdy_q;
   logic                      busy_q;

   logic [BITWIDTH-1:0]       elem_d;
   logic [BITWIDTH-1:0]       x_sel_d;
   logic [BITWIDTH-1:0]       abs_d;
   logic [1:0]                seg_d;
   logic [BITWIDTH-1:0]       y_d;
`ifdef GATE_ACT_TANH_EN
   logic [BITWIDTH:0]         dbl_d;
`endif

   // Element select, with saturating 2x for the tanh identity tanh(x) = 2*sig(2x) - 1.
   always_comb begin
      elem_d  = vec_q[int'(idx_q)*BITWIDTH +: BITWIDTH];
      x_sel_d = elem_d;
`ifdef GATE_ACT_TANH_EN
      dbl_d = {elem_d[BITWIDTH-1], elem_d} << 1;
      if (tanh_q) begin
         if (dbl_d[BITWIDTH] != dbl_d[BITWIDTH-1]) begin
            x_sel_d = dbl_d[BITWIDTH] ? MIN_NEG : MAX_POS;
         end else begin
            x_sel_d = dbl_d[BITWIDTH-1:0];
         end
      end
`endif
   end

   // Magnitude (most-negative clamps to MAX_POS) and segment of the issued element.
   always_comb begin
      abs_d = iss_x_q;
      if (iss_x_q[BITWIDTH-1]) begin
         abs_d = (iss_x_q == MIN_NEG) ? MAX_POS : (~iss_x_q + 1'b1);
      end
      if (abs_d < ONE) begin
         seg_d = 2'd0;
      end else if (abs_d < B_2375) begin
         seg_d = 2'd1;
      end else if (abs_d < B_5) begin
         seg_d = 2'd2;
      end else begin
         seg_d = 2'd3;
      end
   end

   // Piecewise-linear sigmoid on |x|, mirrored for negative inputs.
   always_comb begin
      case (s1_seg_q)
         2'd0:    y_d = (s1_abs_q >> 2) + HALF;
         2'd1:    y_d = (s1_abs_q >> 3) + K_0625;
         2'd2:    y_d = (s1_abs_q >> 5) + K_08438;
         default: y_d = ONE;
      endcase
      if (s1_neg_q) begin
         y_d = ONE - y_d;
      end
`ifdef GATE_ACT_TANH_EN
      if (tanh_q) begin
         y_d = (y_d << 1) - ONE;
      end
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         prev_q    <= 1'b0;
         vec_q     <= '0;
         idx_q     <= '0;
         drain_q   <= 1'b0;
`ifdef GATE_ACT_TANH_EN
         tanh_q    <= 1'b0;
`endif
         iss_vld_q <= 1'b0;
         iss_x_q   <= '0;
         iss_idx_q <= '0;
         s1_vld_q  <= 1'b0;
         s1_neg_q  <= 1'b0;
         s1_abs_q  <= '0;
         s1_seg_q  <= '0;
         s1_idx_q  <= '0;
         act_q     <= '0;
         rdy_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         prev_q    <= dataReady_gate;
         iss_vld_q <= 1'b0;

         s1_vld_q  <= iss_vld_q;
         s1_neg_q  <= iss_x_q[BITWIDTH-1];
         s1_abs_q  <= abs_d;
         s1_seg_q  <= seg_d;
         s1_idx_q  <= iss_idx_q;

         if (s1_vld_q) begin
            act_q[int'(s1_idx_q)*BITWIDTH +: BITWIDTH] <= y_d;
         end

         case (state_q)
            IDLE: begin
               if (dataReady_gate && !prev_q) begin
                  vec_q   <= gateOutput;
`ifdef GATE_ACT_TANH_EN
                  tanh_q  <= tanhSel;
`endif
                  idx_q   <= '0;
                  rdy_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               iss_vld_q <= 1'b1;
               iss_x_q   <= x_sel_d;
               iss_idx_q <= idx_q;
               idx_q     <= idx_q + 1'b1;
               if (idx_q == LAST_IDX) begin
                  drain_q <= 1'b0;
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               // Two cycles let the last element clear stage 1 and stage 2.
               if (drain_q) begin
                  rdy_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  drain_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign actOutput     = act_q;
   assign dataReady_act = rdy_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_gate_activation.sv
// tb/tb_gate_activation.sv - self-checking bench for gate_activation
module tb_gate_activation;

   localparam int HS   = 32;
   localparam int BW   = 18;
   localparam int LW   = BW * HS;
   localparam int ONE  = 2048;
   localparam int MAXV = 131071;
   localparam int MINV = -131072;

   logic          clock   = 1'b0;
   logic          reset   = 1'b1;
   logic          dr_gate = 1'b0;
   logic [LW-1:0] gate_out = '0;
`ifdef GATE_ACT_TANH_EN
   logic          tanh_sel = 1'b0;
`endif
   logic [LW-1:0] act_out;
   logic          rdy_act;
   logic          busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int t_cap  = 0;

   always #5 clock = ~clock;

   gate_activation #(.HIDDEN_SZ(HS), .QN(6), .QM(11)) dut (
      .clock          (clock),
      .reset          (reset),
      .gateOutput     (gate_out),
      .dataReady_gate (dr_gate),
`ifdef GATE_ACT_TANH_EN
      .tanhSel        (tanh_sel),
`endif
      .actOutput      (act_out),
      .dataReady_act  (rdy_act),
      .busy           (busy)
   );

   // Reference activation straight from the real-valued rules, scaled by 2048.
   function automatic int sig_fn(input int x);
      int a;
      int y;
      a = (x < 0) ? -x : x;
      if (a > MAXV) a = MAXV;
      if (a < ONE)                 y = a / 4 + ONE / 2;
      else if (8 * a < 19 * ONE)   y = a / 8 + (ONE * 5) / 8;
      else if (a < 5 * ONE)        y = a / 32 + (ONE * 27) / 32;
      else                         y = ONE;
      if (x < 0) y = ONE - y;
      return y;
   endfunction

   function automatic int act_fn(input int x, input bit th);
      int x2;
      if (!th) return sig_fn(x);
      x2 = 2 * x;
      if (x2 > MAXV) x2 = MAXV;
      if (x2 < MINV) x2 = MINV;
      return 2 * sig_fn(x2) - ONE;
   endfunction

   // Timing model: capture at edge C, slot k updated at C+3+k, done at C+HS+2.
   int                  m_x [HS];
   int                  m_act [HS];
   bit                  m_th, m_op, m_rdy, m_prev, m_valid;
   int                  m_cap;
   logic signed [BW-1:0] m_tmp;

   always @(posedge clock) begin
      cyc++;
      if (reset) begin
         m_valid = 1'b1;
         m_op    = 1'b0;
         m_rdy   = 1'b0;
         m_prev  = 1'b0;
         for (int k = 0; k < HS; k++) m_act[k] = 0;
      end else if (m_valid) begin
         if (!m_op && dr_gate && !m_prev) begin
            m_cap = cyc;
            m_op  = 1'b1;
            m_rdy = 1'b0;
            for (int k = 0; k < HS; k++) begin
               m_tmp  = gate_out[k*BW +: BW];
               m_x[k] = int'(m_tmp);
            end
`ifdef GATE_ACT_TANH_EN
            m_th = tanh_sel;
`else
            m_th = 1'b0;
`endif
         end
         m_prev = dr_gate;
         if (m_op) begin
            for (int k = 0; k < HS; k++)
               if (cyc == m_cap + 3 + k) m_act[k] = act_fn(m_x[k], m_th);
            if (cyc == m_cap + HS + 2) begin
               m_op  = 1'b0;
               m_rdy = 1'b1;
            end
         end
      end
   end

   logic [BW-1:0] c_got;
   logic [BW-1:0] c_exp;
   int            c_bad;

   always @(negedge clock) begin
      if (m_valid) begin
         checks++;
         if (busy !== m_op) begin
            errors++;
            $display("FAIL busy cyc=%0d got=%b expected=%b", cyc, busy, m_op);
         end
         checks++;
         if (rdy_act !== m_rdy) begin
            errors++;
            $display("FAIL dataReady_act cyc=%0d got=%b expected=%b", cyc, rdy_act, m_rdy);
         end
         checks++;
         c_bad = -1;
         for (int k = 0; k < HS; k++) begin
            c_got = act_out[k*BW +: BW];
            c_exp = m_act[k][BW-1:0];
            if (c_got !== c_exp && c_bad < 0) c_bad = k;
         end
         if (c_bad >= 0) begin
            errors++;
            c_got = act_out[c_bad*BW +: BW];
            c_exp = m_act[c_bad][BW-1:0];
            $display("FAIL actOutput cyc=%0d slot=%0d got=%0d expected=%0d",
                     cyc, c_bad, $signed(c_got), $signed(c_exp));
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask

   function automatic int slot(input int k);
      logic signed [BW-1:0] s;
      s = act_out[k*BW +: BW];
      return int'(s);
   endfunction

   task automatic put(input int k, input int v);
      gate_out[k*BW +: BW] = BW'(v);
   endtask

   task automatic capture(input bit ts);
`ifdef GATE_ACT_TANH_EN
      tanh_sel = ts;
`endif
      if (ts && 0) dr_gate = 1'b0;
      dr_gate = 1'b1;
      tick();
      t_cap   = cyc;
      dr_gate = 1'b0;
   endtask

   task automatic wait_ready(output int lat);
      int n;
      n = 0;
      while (!rdy_act && n < 60) begin
         tick();
         n++;
      end
      checks++;
      if (!rdy_act) begin
         errors++;
         $display("FAIL ready_timeout got=0 expected=1 after %0d cycles", n);
      end
      lat = cyc - t_cap;
   endtask

   initial begin
      int lat;
      int c;

      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      chk("reset_busy", int'(busy), 0);
      chk("reset_ready", int'(rdy_act), 0);
      chk("reset_act_ones", $countones(act_out), 0);

      // Segment midpoints and mirror.
      gate_out = '0;
      put(0, 0); put(1, 4096); put(2, -4096); put(3, 6144); put(4, 12288);
      capture(1'b0);
      wait_ready(lat);
      chk("t1_latency", lat, 34);
      chk("t1_s0", slot(0), 1024);
      chk("t1_s1", slot(1), 1792);
      chk("t1_s2", slot(2), 256);
      chk("t1_s3", slot(3), 1920);
      chk("t1_s4", slot(4), 2048);
      chk("t1_s5", slot(5), 1024);

      // Segment boundaries and most-negative saturation.
      gate_out = '0;
      put(0, 2048); put(1, 4864); put(2, 10240); put(3, -131072);
      capture(1'b0);
      wait_ready(lat);
      chk("t2_s0", slot(0), 1536);
      chk("t2_s1", slot(1), 1880);
      chk("t2_s2", slot(2), 2048);
      chk("t2_s3", slot(3), 0);

`ifdef GATE_ACT_TANH_EN
      gate_out = '0;
      put(0, 1024); put(1, 0); put(2, -1024); put(3, 131071);
      capture(1'b1);
      wait_ready(lat);
      chk("t3_s0", slot(0), 1024);
      chk("t3_s1", slot(1), 0);
      chk("t3_s2", slot(2), -1024);
      chk("t3_s3", slot(3), 2048);
`endif

      // Second rising edge while running is ignored.
      gate_out = '0;
      put(0, 4096); put(1, -4096);
      capture(1'b0);
      c = t_cap;
      while (cyc < c + 9) tick();
      gate_out = '0;
      put(0, 12288); put(1, 12288);
      dr_gate = 1'b1;
      while (cyc < c + 33) tick();
      chk("t4_busy_c33", int'(busy), 1);
      tick();
      chk("t4_busy_c34", int'(busy), 0);
      chk("t4_ready_c34", int'(rdy_act), 1);
      chk("t4_s0", slot(0), 1792);
      chk("t4_s1", slot(1), 256);
      tick();
      tick();
      chk("t4_no_recapture", int'(busy), 0);
      dr_gate = 1'b0;
      tick();

      // Reset mid-run aborts, then a fresh vector completes.
      gate_out = '0;
      put(0, 6144);
      capture(1'b0);
      c = t_cap;
      while (cyc < c + 14) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t5_busy", int'(busy), 0);
      chk("t5_ready", int'(rdy_act), 0);
      chk("t5_act_ones", $countones(act_out), 0);
      gate_out = '0;
      put(0, -6144);
      capture(1'b0);
      wait_ready(lat);
      chk("t5_latency", lat, 34);
      chk("t5_s0", slot(0), 128);

      // Back-to-back captures at C and C+35.
      gate_out = '0;
      put(0, 4096);
      capture(1'b0);
      c = t_cap;
      wait_ready(lat);
      chk("t6_first_s0", slot(0), 1792);
      gate_out = '0;
      put(0, -4096);
      capture(1'b0);
      chk("t6_gap", t_cap - c, 35);
      chk("t6_ready_clear", int'(rdy_act), 0);
      wait_ready(lat);
      chk("t6_latency", lat, 34);
      chk("t6_second_s0", slot(0), 256);

      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
